// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register: IR, control and payload with a valid/ready handshake, a 2-entry skid buffer and flush-to-bubble.
// Define PIPE_STAGE_STATS_EN to build the saturating stall/flush statistics counters.
module pipeline_stage_reg #(
    parameter int                DATA_W    = 96,
    parameter int                IR_W      = 16,
    parameter logic [IR_W-1:0]   NOP_IR    = 16'hF000,
    parameter int                CTRL_W    = 8,
    parameter logic [CTRL_W-1:0] CTRL_SAFE = 8'h01,
    parameter int                SKID      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IR_W-1:0]   out_ir,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [15:0]       stat_stall,
    output logic [15:0]       stat_flush
);

    logic              mValid, sValid;
    logic [IR_W-1:0]   mIr, sIr;
    logic [CTRL_W-1:0] mCtrl, sCtrl;
    logic [DATA_W-1:0] mData, sData;
    logic              inXfer, outXfer, mFree;

    // With the skid entry, in_ready is pure registered state so out_ready never reaches upstream combinationally.
    assign in_ready  = (SKID != 0) ? !sValid : (!mValid || out_ready);
    assign inXfer    = in_valid && in_ready;
    assign outXfer   = mValid && out_ready;
    assign mFree     = outXfer || !mValid;
    assign occupancy = {1'b0, mValid} + {1'b0, sValid};

    // NOTE: only the valid bits and the visible payload are reset; IR/control are masked by the valid bit
    // and the skid payload is never observed while invalid, so those data registers need no reset.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignment so M can take S and S can take the input on the same edge.
        if (reset) begin
            mValid <= 1'b0;
            sValid <= 1'b0;
            mData  <= '0;
        end else if (flush) begin
            mValid <= 1'b0;
            sValid <= 1'b0;
        end else if (mFree) begin
            if (sValid) begin
                mValid <= 1'b1;
                mIr    <= sIr;
                mCtrl  <= sCtrl;
                mData  <= sData;
                sValid <= inXfer;
                if (inXfer) begin
                    sIr   <= in_ir;
                    sCtrl <= in_ctrl;
                    sData <= in_data;
                end
            end else begin
                mValid <= inXfer;
                if (inXfer) begin
                    mIr   <= in_ir;
                    mCtrl <= in_ctrl;
                    mData <= in_data;
                end
            end
        end else if (inXfer && (SKID != 0)) begin
            sValid <= 1'b1;
            sIr    <= in_ir;
            sCtrl  <= in_ctrl;
            sData  <= in_data;
        end
    end

    assign out_valid = mValid;
    assign out_ir    = mValid ? mIr : NOP_IR;
    assign out_ctrl  = mValid ? mCtrl : CTRL_SAFE;
    assign out_data  = mData;

`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stallCnt, flushCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (mValid && !out_ready && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
            if (flush && (occupancy != 2'd0) && (flushCnt != 16'hFFFF)) flushCnt <= flushCnt + 16'd1;
        end
    end

    assign stat_stall = stallCnt;
    assign stat_flush = flushCnt;
`else
    assign stat_stall = 16'd0;
    assign stat_flush = 16'd0;
`endif

endmodule

// File: doc/pipeline_stage_reg.md
Name: pipeline_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the RISC pipeline.
- Replaces the hand-built per-stage register banks with one block that carries:
  - an instruction word (IR),
  - a control-field vector,
  - a data payload.
- Adds a valid/ready handshake, a 2-entry skid buffer for stalls, and synchronous flush that injects a NOP bubble.
- Instantiated between every pair of stages (IF/ID, ID/RR, RR/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 96, payload width in bits (immediates, PC values, RF read data, ...).
- IR_W, 16, instruction word width.
- NOP_IR, 16'hF000, IR value presented whenever the stage holds a bubble.
- CTRL_W, 8, control vector width (write-enables, mux selects).
- CTRL_SAFE, 8'h01, control value presented on a bubble; encodes all write-enables inactive (includes active-low mem write = 1).
- SKID, 1, 1 = 2-entry skid buffer; 0 = single register, combinational ready path.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash stage contents and any input accepted this cycle.
- in_valid  in  1  upstream has a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ir  in  IR_W  incoming instruction.
- in_ctrl  in  CTRL_W  incoming control vector.
- in_data  in  DATA_W  incoming payload.
- out_valid  out  1  stage holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_ir  out  IR_W  registered instruction (NOP_IR when !out_valid).
- out_ctrl  out  CTRL_W  registered control (CTRL_SAFE when !out_valid).
- out_data  out  DATA_W  registered payload.
- occupancy  out  2  entries held: 0, 1 or 2.
- stat_stall  out  16  stall-cycle counter (optional feature).
- stat_flush  out  16  flush-event counter (optional feature).

Behaviour:
- Storage and transfers:
  - Storage is main entry M plus, when SKID=1, skid entry S.
  - Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
  - Latency 1 cycle: a word accepted at edge N is on the outputs after edge N.
- in_ready:
  - SKID=1: in_ready = !S.valid. It is registered state only; no combinational path from out_ready.
  - SKID=0: in_ready = !M.valid || out_ready.
- Update rules (SKID=1), in priority order each edge:
  - reset: M, S invalid; out_data = 0.
  - flush: M, S invalid; the input transfer of that cycle is discarded.
  - Otherwise:
    - If the output transfers or M is empty: M takes S if S is valid, else the input word (if any). In the S case, an accepted input word goes to the freed S.
    - If M is valid, there is no output transfer, and input is accepted: the input goes to S.
- Ordering is strict FIFO; no entry is ever overwritten or lost without a flush.
- Simultaneous input and output transfers with occupancy 1 keep occupancy 1 (pass-through).
- Occupancy 2 ⇒ in_ready = 0 the next cycle. in_ready rises one cycle after an output transfer drains S.
- Bubble presentation when !out_valid:
  - out_ir = NOP_IR and out_ctrl = CTRL_SAFE, forced combinationally from the valid bit.
  - out_data holds its last value; it is don't-care.
- Reset values: out_valid = 0, in_ready = 1, out_ir = NOP_IR, out_ctrl = CTRL_SAFE, out_data = 0, occupancy = 0, stat counters = 0.
- Flush while stalled with occupancy 2: both entries are dropped, and the next cycle occupancy = 0 and in_ready = 1.
- Reset has priority over flush. Flush has priority over all transfers.
- out_valid must not depend combinationally on out_ready (AXI-style rule: once asserted, it stays asserted and the contents are stable until a transfer or flush).

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - stat_stall increments each cycle with out_valid && !out_ready.
  - stat_flush increments each cycle with flush asserted and occupancy > 0.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: no counter logic; stat_stall and stat_flush are tied to 0.

Test Plan:
- Reset, then idle: out_valid = 0, out_ir = 16'hF000, out_ctrl = 8'h01, in_ready = 1, occupancy = 0.
- Streaming with out_ready = 1, IR 16'h1234 then 16'h5678 back-to-back: out_ir follows one cycle later each, occupancy stays 1, in_ready never drops.
- Stall with out_ready = 0 while sending A = 16'h1111, B = 16'h2222:
  - occupancy goes 1 then 2, and in_ready = 0.
  - Releasing out_ready yields A then B in order; in_ready returns one cycle after B moves to M.
- Flush at occupancy 2 with a concurrent in_valid word C = 16'h3333: next cycle out_valid = 0, out_ir = 16'hF000, occupancy = 0; C is never emitted.
- Reset asserted together with flush and in_valid: all outputs take reset values; with PIPE_STAGE_STATS_EN defined, stat_flush = 0.
- PIPE_STAGE_STATS_EN defined, hold out_ready = 0 for 70000 cycles with the stage full: stat_stall saturates at 16'hFFFF.
